mrd_completion_tracker: RTL and testbench

- Requester-side counterpart to the completer header translator.
- Accepts local memory-read requests, allocates a tag, and emits a 3DW MRd TLP header toward the link.
- Consumes returning completion headers and matches them against outstanding tags by requester ID and tag.
- Tracks remaining byte count per tag; retires each tag on final completion, error status or timeout, reporting one retirement per cycle.

---
 rtl/mrd_completion_tracker.sv | 174 +++++++++++++++++
 tb/tb_mrd_completion_tracker.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mrd_completion_tracker.sv
// Requester-side MRd tag tracker: allocates tags, builds 3DW MRd headers, matches
// returning completions by requester ID/tag and retires tags on completion, error or timeout.
module mrd_completion_tracker #(
  parameter int          TAG_COUNT      = 8,
  parameter int          TAG_W          = 3,
  parameter int          TIMEOUT_CYCLES = 1024,
  parameter logic [15:0] REQUESTER_ID   = 16'h0100
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [29:0]      req_addr,
  input  logic [9:0]       req_length,
  output logic [TAG_W-1:0] req_tag,
  output logic             hdr_valid,
  input  logic             hdr_ready,
  output logic [95:0]      hdr_out,
  input  logic             cpl_valid,
  input  logic [95:0]      cpl_header,
  output logic             cpl_ready,
  output logic             done_valid,
  output logic [TAG_W-1:0] done_tag,
  output logic [1:0]       done_status,
  output logic [TAG_W:0]   outstanding,
  output logic [7:0]       unexpected_cnt
);

  localparam int TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(TIMEOUT_CYCLES - 1);

  function automatic logic [12:0] dw_bytes(input logic [9:0] len);
    return (len == 10'd0) ? 13'd4096 : {1'b0, len, 2'b00};
  endfunction

  logic [TAG_COUNT-1:0] busy_r;
  logic [12:0]          remaining_r [TAG_COUNT];
  logic [TMR_W-1:0]     timer_r     [TAG_COUNT];
  logic                 hdr_valid_r;
  logic [95:0]          hdr_out_r;
  logic                 done_valid_r;
  logic [TAG_W-1:0]     done_tag_r;
  logic [1:0]           done_status_r;
  logic [7:0]           unexpected_r;

  logic [TAG_W-1:0] free_tag_s, to_tag_s, cpl_idx_s, retire_tag_s;
  logic             to_any_s, accept_s, cpl_hit_s, cpl_retire_s, partial_s, retire_any_s;
  logic [1:0]       cpl_status_s, retire_status_s;
  logic [TAG_W:0]   outstanding_s;
  logic [12:0]      cpl_bytes_s, cpl_len_bytes_s, cpl_rem_s;
  logic [95:0]      mrd_hdr_s;
  logic [3:0]       last_be_s;
  logic             fmt_ok_s;

  // Lowest free tag, lowest timed-out tag and busy popcount.
  always_comb begin
    free_tag_s    = '0;
    to_tag_s      = '0;
    to_any_s      = 1'b0;
    outstanding_s = '0;
    for (int i = TAG_COUNT - 1; i >= 0; i--) begin
      free_tag_s    = busy_r[i] ? free_tag_s : TAG_W'(i);
      to_tag_s      = (busy_r[i] && (timer_r[i] == TMR_MAX)) ? TAG_W'(i) : to_tag_s;
      to_any_s      = to_any_s | (busy_r[i] && (timer_r[i] == TMR_MAX));
      outstanding_s = outstanding_s + (TAG_W+1)'(busy_r[i]);
    end
  end

  assign req_ready = (~&busy_r) && (!hdr_valid_r || hdr_ready);
  assign req_tag   = free_tag_s;
  assign accept_s  = req_valid && req_ready;
  assign last_be_s = (req_length == 10'd1) ? 4'h0 : 4'hF;
  assign mrd_hdr_s = {req_addr, 2'b00, REQUESTER_ID, 8'(free_tag_s), last_be_s, 4'hF,
                      3'b000, 5'b00000, 14'd0, req_length};

  assign cpl_idx_s       = cpl_header[72 +: TAG_W];
  assign fmt_ok_s        = (cpl_header[31:29] == 3'b000) || (cpl_header[31:29] == 3'b010);
  assign cpl_hit_s       = cpl_valid && fmt_ok_s && (cpl_header[28:24] == 5'b01010) &&
                           (cpl_header[95:80] == REQUESTER_ID) &&
                           (cpl_header[79:72] < 8'(TAG_COUNT)) && busy_r[cpl_idx_s];
  assign cpl_bytes_s     = (cpl_header[43:32] == 12'd0) ? 13'd4096 : {1'b0, cpl_header[43:32]};
  assign cpl_len_bytes_s = dw_bytes(cpl_header[9:0]);
  assign cpl_rem_s       = remaining_r[cpl_idx_s];

  // Completion outcome and retirement arbitration; a completion beats any timeout.
  always_comb begin
    cpl_retire_s = 1'b0;
    cpl_status_s = 2'b00;
    partial_s    = 1'b0;
    if (!cpl_hit_s) begin
      cpl_retire_s = 1'b0;
    end else if (cpl_header[47:45] != 3'b000) begin
      cpl_retire_s = 1'b1;
      cpl_status_s = 2'b01;
    end else if (cpl_bytes_s != cpl_rem_s) begin
      cpl_retire_s = 1'b1;
      cpl_status_s = 2'b11;
    end else if (cpl_bytes_s <= cpl_len_bytes_s) begin
      cpl_retire_s = 1'b1;
      cpl_status_s = 2'b00;
    end else begin
      partial_s = 1'b1;
    end
    retire_any_s    = cpl_retire_s | to_any_s;
    retire_tag_s    = cpl_retire_s ? cpl_idx_s : to_tag_s;
    retire_status_s = cpl_retire_s ? cpl_status_s : 2'b10;
  end

  // Header channel, done pulse and dropped-completion counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hdr_valid_r   <= 1'b0;
      hdr_out_r     <= 96'd0;
      done_valid_r  <= 1'b0;
      done_tag_r    <= '0;
      done_status_r <= 2'b00;
      unexpected_r  <= 8'd0;
    end else begin
      if (accept_s) begin
        hdr_valid_r <= 1'b1;
        hdr_out_r   <= mrd_hdr_s;
      end else if (hdr_ready) begin
        hdr_valid_r <= 1'b0;
      end
      done_valid_r <= retire_any_s;
      if (retire_any_s) begin
        done_tag_r    <= retire_tag_s;
        done_status_r <= retire_status_s;
      end
      if (cpl_valid && !cpl_hit_s && (unexpected_r != 8'hFF)) begin
        unexpected_r <= unexpected_r + 8'd1;
      end
    end
  end

  // Per-tag busy flag, remaining byte count and age timer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_r <= '0;
      for (int i = 0; i < TAG_COUNT; i++) begin
        remaining_r[i] <= 13'd0;
        timer_r[i]     <= '0;
      end
    end else begin
      for (int i = 0; i < TAG_COUNT; i++) begin
        if (accept_s && (free_tag_s == TAG_W'(i))) begin
          busy_r[i]      <= 1'b1;
          remaining_r[i] <= dw_bytes(req_length);
          timer_r[i]     <= '0;
        end else begin
          if (retire_any_s && (retire_tag_s == TAG_W'(i))) begin
            busy_r[i] <= 1'b0;
          end
          if (partial_s && (cpl_idx_s == TAG_W'(i))) begin
            remaining_r[i] <= cpl_bytes_s - cpl_len_bytes_s;
          end
          if (busy_r[i] && (timer_r[i] != TMR_MAX)) begin
            timer_r[i] <= timer_r[i] + TMR_W'(1);
          end
        end
      end
    end
  end

  assign hdr_valid      = hdr_valid_r;
  assign hdr_out        = hdr_out_r;
  assign cpl_ready      = 1'b1;
  assign done_valid     = done_valid_r;
  assign done_tag       = done_tag_r;
  assign done_status    = done_status_r;
  assign outstanding    = outstanding_s;
  assign unexpected_cnt = unexpected_r;

endmodule

// File: tb/tb_mrd_completion_tracker.sv
// Scoreboard bench for mrd_completion_tracker: a tag-level reference model predicts
// allocations, headers and retirements; monitors compare what the DUT presents.
module tb_mrd_completion_tracker;

  localparam int          TAGS    = 8;
  localparam int          TIMEOUT = 1024;
  localparam logic [15:0] RID     = 16'h0100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0, req_ready;
  logic [29:0] req_addr = 30'd0;
  logic [9:0]  req_length = 10'd0;
  logic [2:0]  req_tag;
  logic        hdr_valid, hdr_ready = 1'b0;
  logic [95:0] hdr_out;
  logic        cpl_valid = 1'b0, cpl_ready;
  logic [95:0] cpl_header = 96'd0;
  logic        done_valid;
  logic [2:0]  done_tag;
  logic [1:0]  done_status;
  logic [3:0]  outstanding;
  logic [7:0]  unexpected_cnt;

  mrd_completion_tracker dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_length(req_length), .req_tag(req_tag),
    .hdr_valid(hdr_valid), .hdr_ready(hdr_ready), .hdr_out(hdr_out),
    .cpl_valid(cpl_valid), .cpl_header(cpl_header), .cpl_ready(cpl_ready),
    .done_valid(done_valid), .done_tag(done_tag), .done_status(done_status),
    .outstanding(outstanding), .unexpected_cnt(unexpected_cnt)
  );

  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;

  // Reference model state: per-tag busy / bytes still owed / age in cycles.
  bit  m_busy [TAGS];
  int  m_rem  [TAGS];
  int  m_age  [TAGS];
  bit  m_hdr_pend = 1'b0;
  int  m_unexp = 0;
  logic [95:0] hq [$];
  logic [4:0]  dq [$];

  // Fields of the completion currently being driven.
  logic [7:0]  c_tag;
  logic [2:0]  c_status, c_fmt;
  logic [11:0] c_bc;
  logic [9:0]  c_len;
  logic [15:0] c_rid;
  logic [4:0]  c_type;

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [95:0] mk_mrd(input logic [29:0] addr, input logic [9:0] len, input int tag);
    logic [95:0] h;
    h = 96'd0;
    h[95:66] = addr;
    h[63:48] = RID;
    h[47:40] = 8'(tag);
    h[39:36] = (len == 10'd1) ? 4'h0 : 4'hF;
    h[35:32] = 4'hF;
    h[9:0]   = len;
    return h;
  endfunction

  task automatic send_cpl(input logic [7:0] tag, input logic [2:0] st, input logic [11:0] bc,
                          input logic [9:0] len, input logic [15:0] rid, input logic [2:0] fmt,
                          input logic [4:0] typ);
    logic [95:0] h;
    c_tag = tag; c_status = st; c_bc = bc; c_len = len; c_rid = rid; c_fmt = fmt; c_type = typ;
    h = 96'd0;
    h[31:29] = fmt;  h[28:24] = typ;  h[9:0]   = len;
    h[63:48] = 16'h0200; h[47:45] = st; h[43:32] = bc;
    h[95:80] = rid;  h[79:72] = tag;
    cpl_header = h;
    cpl_valid  = 1'b1;
  endtask

  task automatic good_cpl(input int tag, input int bc, input int len_dw);
    send_cpl(8'(tag), 3'b000, 12'(bc), 10'(len_dw), RID, 3'b000, 5'b01010);
  endtask

  task automatic request(input logic [29:0] addr, input logic [9:0] len);
    req_valid = 1'b1; req_addr = addr; req_length = len;
  endtask

  // Advance the model across the coming clock edge, using the inputs now applied.
  task automatic model_step();
    int  lo_free, to_tag, nb, bcb, lb;
    bit  exp_ready, acc, hit, cret;
    logic [1:0] cst;
    lo_free = -1; to_tag = -1; nb = 0; cret = 1'b0; cst = 2'b00;
    for (int i = TAGS - 1; i >= 0; i--) begin
      if (!m_busy[i]) lo_free = i;
      if (m_busy[i] && m_age[i] >= TIMEOUT - 1) to_tag = i;
      if (m_busy[i]) nb++;
    end
    exp_ready = (lo_free >= 0) && (!m_hdr_pend || hdr_ready);
    check("req_ready", 96'(req_ready), 96'(exp_ready));
    if (exp_ready) check("req_tag", 96'(req_tag), 96'(lo_free));
    check("outstanding", 96'(outstanding), 96'(nb));
    check("unexpected_cnt", 96'(unexpected_cnt), 96'(m_unexp));
    acc = req_valid && exp_ready;
    if (cpl_valid) begin
      hit = (c_fmt == 3'b000 || c_fmt == 3'b010) && c_type == 5'b01010 && c_rid == RID &&
            int'(c_tag) < TAGS && m_busy[int'(c_tag) % TAGS];
      if (!hit) begin
        if (m_unexp < 255) m_unexp++;
      end else begin
        bcb = (c_bc == 12'd0) ? 4096 : int'(c_bc);
        lb  = ((c_len == 10'd0) ? 1024 : int'(c_len)) * 4;
        if (c_status != 3'b000) begin cret = 1'b1; cst = 2'b01; end
        else if (bcb != m_rem[c_tag]) begin cret = 1'b1; cst = 2'b11; end
        else if (bcb <= lb) begin cret = 1'b1; cst = 2'b00; end
        else m_rem[c_tag] = bcb - lb;
      end
    end
    for (int i = 0; i < TAGS; i++) if (m_busy[i]) m_age[i]++;
    if (cret) begin
      dq.push_back({c_tag[2:0], cst});
      m_busy[c_tag] = 1'b0;
    end else if (to_tag >= 0) begin
      dq.push_back({3'(to_tag), 2'b10});
      m_busy[to_tag] = 1'b0;
    end
    if (acc) begin
      m_busy[lo_free] = 1'b1;
      m_rem[lo_free]  = ((req_length == 10'd0) ? 1024 : int'(req_length)) * 4;
      m_age[lo_free]  = 0;
      hq.push_back(mk_mrd(req_addr, req_length, lo_free));
    end
    m_hdr_pend = acc ? 1'b1 : (hdr_ready ? 1'b0 : m_hdr_pend);
  endtask

  task automatic tick();
    @(negedge clk);
    model_step();
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    cpl_valid = 1'b0;
  endtask

  task automatic model_clear();
    for (int i = 0; i < TAGS; i++) begin m_busy[i] = 1'b0; m_rem[i] = 0; m_age[i] = 0; end
    m_hdr_pend = 1'b0; m_unexp = 0;
    hq.delete(); dq.delete();
  endtask

  // Monitor: compare presented headers/done pulses against the scoreboard queues.
  logic        prev_v, prev_r;
  logic [95:0] prev_h;
  logic [95:0] eh;
  logic [4:0]  ed;
  always @(negedge clk) begin
    if (rst) begin
      prev_v <= 1'b0;
      prev_r <= 1'b0;
      prev_h <= 96'd0;
    end else begin
      if (prev_v && !prev_r) begin
        check("hdr_hold_valid", 96'(hdr_valid), 96'(1'b1));
        check("hdr_hold_data", hdr_out, prev_h);
      end
      if (done_valid) begin
        if (dq.size() == 0) check("done_unexpected", 96'({done_tag, done_status}), 96'h1FF);
        else begin
          ed = dq.pop_front();
          check("done", 96'({done_tag, done_status}), 96'(ed));
        end
      end
      if (hdr_valid && hdr_ready) begin
        if (hq.size() == 0) check("hdr_unexpected", hdr_out, ~hdr_out);
        else begin
          eh = hq.pop_front();
          check("hdr", hdr_out, eh);
        end
      end
      prev_v <= hdr_valid;
      prev_r <= hdr_ready;
      prev_h <= hdr_out;
    end
  end

  initial begin
    int lst [$];
    int t, rem, k, l, guard;
    model_clear();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_outstanding", 96'(outstanding), 96'd0);
    check("rst_hdr_valid", 96'(hdr_valid), 96'd0);
    check("rst_done_valid", 96'(done_valid), 96'd0);
    check("rst_unexpected", 96'(unexpected_cnt), 96'd0);
    check("rst_req_tag", 96'(req_tag), 96'd0);
    check("rst_cpl_ready", 96'(cpl_ready), 96'd1);

    // First request with header held off for three cycles.
    request(30'h100, 10'd2);
    tick();
    check("hdr_valid_rise", 96'(hdr_valid), 96'd1);
    check("hdr_len", 96'(hdr_out[9:0]), 96'd2);
    check("hdr_tag", 96'(hdr_out[47:40]), 96'd0);
    check("hdr_be", 96'(hdr_out[39:32]), 96'hFF);
    check("hdr_rid", 96'(hdr_out[63:48]), 96'h0100);
    check("hdr_addr", 96'(hdr_out[95:66]), 96'h100);
    repeat (3) tick();
    hdr_ready = 1'b1;
    tick();
    good_cpl(0, 8, 2);
    tick();
    check("cpl_done_valid", 96'(done_valid), 96'd1);
    check("cpl_done", 96'({done_tag, done_status}), 96'({3'd0, 2'b00}));
    check("cpl_outstanding", 96'(outstanding), 96'd0);

    // Split completion, then split completion with a wrong final byte count.
    request(30'h200, 10'd4); tick();
    good_cpl(0, 16, 2); tick();
    check("partial_no_done", 96'(done_valid), 96'd0);
    check("partial_busy", 96'(outstanding), 96'd1);
    good_cpl(0, 8, 2); tick();
    check("split_done", 96'({done_valid, done_tag, done_status}), 96'({1'b1, 3'd0, 2'b00}));
    request(30'h300, 10'd4); tick();
    good_cpl(0, 16, 2); tick();
    good_cpl(0, 12, 2); tick();
    check("bcm_done", 96'({done_valid, done_tag, done_status}), 96'({1'b1, 3'd0, 2'b11}));

    // Fill all tags, refuse the ninth, free tag 3 and reuse it.
    for (int i = 0; i < TAGS; i++) begin
      request(30'(i * 16), 10'd2);
      #1 check("alloc_tag", 96'(req_tag), 96'(i));
      tick();
    end
    request(30'h3FF, 10'd1);
    #1 check("full_not_ready", 96'(req_ready), 96'd0);
    tick();
    request(30'h3FF, 10'd1);
    good_cpl(3, 8, 2);
    tick();
    request(30'h3FF, 10'd1);
    #1 check("reuse_tag", 96'({req_ready, req_tag}), 96'({1'b1, 3'd3}));
    tick();
    repeat (1100) tick();
    check("timeouts_drained", 96'(outstanding), 96'd0);

    // Completion on tag 0 in the same cycle tag 1 times out.
    request(30'h10, 10'd2); tick();
    request(30'h20, 10'd2); tick();
    good_cpl(0, 8, 2); tick();
    request(30'h30, 10'd2); tick();
    guard = 0;
    while (m_age[1] < TIMEOUT - 1 && guard < 1100) begin tick(); guard++; end
    check("tmo_wait_bound", 96'(guard < 1100), 96'd1);
    good_cpl(0, 8, 2); tick();
    check("race_cpl_first", 96'({done_valid, done_tag, done_status}), 96'({1'b1, 3'd0, 2'b00}));
    tick();
    check("race_tmo_next", 96'({done_valid, done_tag, done_status}), 96'({1'b1, 3'd1, 2'b10}));

    // Dropped completions and saturation.
    request(30'h40, 10'd2); tick();
    send_cpl(8'd0, 3'b000, 12'd8, 10'd2, 16'h0101, 3'b000, 5'b01010); tick();
    send_cpl(8'd5, 3'b000, 12'd8, 10'd2, RID, 3'b000, 5'b01010); tick();
    send_cpl(8'd0, 3'b000, 12'd8, 10'd2, RID, 3'b000, 5'b00000); tick();
    tick();
    check("unexpected_3", 96'(unexpected_cnt), 96'd3);
    check("drop_keeps_busy", 96'(outstanding), 96'd1);
    repeat (260) begin
      send_cpl(8'd200, 3'b000, 12'd8, 10'd2, RID, 3'b000, 5'b01010);
      tick();
    end
    check("unexpected_sat", 96'(unexpected_cnt), 96'd255);
    for (int i = 0; i < 3; i++) begin request(30'(i), 10'd1); tick(); end
    check("pre_rst_outstanding", 96'(outstanding), 96'd4);
    rst = 1'b1;
    #1;
    check("async_rst_outstanding", 96'(outstanding), 96'd0);
    check("async_rst_hdr_valid", 96'(hdr_valid), 96'd0);
    check("async_rst_unexpected", 96'(unexpected_cnt), 96'd0);
    model_clear();
    @(posedge clk);
    #1 rst = 1'b0;

    // Randomized traffic with stalls, split completions, errors and drops.
    for (int cyc = 0; cyc < 1500; cyc++) begin
      hdr_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 2) == 0) request(30'($urandom), 10'($urandom_range(0, 24)));
      lst.delete();
      for (int i = 0; i < TAGS; i++) if (m_busy[i]) lst.push_back(i);
      if (lst.size() > 0 && $urandom_range(0, 1) == 1) begin
        t = lst[$urandom_range(0, lst.size() - 1)];
        rem = m_rem[t];
        k = $urandom_range(0, 9);
        case (k)
          0: send_cpl(8'(t), 3'($urandom_range(1, 7)), 12'(rem), 10'd1, RID, 3'b000, 5'b01010);
          1: send_cpl(8'(t), 3'b000, (rem == 8) ? 12'd16 : 12'd8, 10'd2, RID, 3'b010, 5'b01010);
          2: send_cpl(8'(t), 3'b000, 12'(rem), 10'd2, 16'h0F00, 3'b000, 5'b01010);
          default: begin
            l = $urandom_range(1, rem / 4);
            if ($urandom_range(0, 2) == 0) l = rem / 4;
            send_cpl(8'(t), 3'b000, 12'(rem), 10'(l), RID,
                     ($urandom_range(0, 1) == 1) ? 3'b010 : 3'b000, 5'b01010);
          end
        endcase
      end
      tick();
    end

    hdr_ready = 1'b1;
    repeat (1100) tick();
    check("final_outstanding", 96'(outstanding), 96'd0);
    check("final_done_q", 96'(dq.size()), 96'd0);
    check("final_hdr_q", 96'(hq.size()), 96'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
